// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - Zicsr encodings, FSM states and CSR addresses for csr_access_unit
package csr_access_unit_pkg;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // funct3[1:0] selects the operation independently of the immediate bit
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [11:0] MSR_MSTATUS  = 12'h300;
    localparam logic [11:0] MSR_MSCRATCH = 12'h340;
    localparam logic [11:0] MSR_MTAGS    = 12'h7C0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE
    } state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// rtl/csr_access_unit_alu.sv - combinational RW/RS/RC new-value compute
module csr_access_unit_alu
    import csr_access_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   i_kind,
    input  logic [W-1:0] i_old,
    input  logic [W-1:0] i_op,
    output logic [W-1:0] o_new
);

    always_comb begin
        o_new = i_old;
        case (i_kind)
            OP_RW:   o_new = i_op;
            OP_RS:   o_new = i_old | i_op;
            OP_RC:   o_new = i_old & ~i_op;
            default: o_new = i_old;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Zicsr read/modify/write sequencer toward the machine CSR file
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int CSR_DATA_WIDTH = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [2:0]                funct3_i,
    input  logic [CSR_ADDR_WIDTH-1:0] addr_i,
    input  logic [CSR_DATA_WIDTH-1:0] rs1_data_i,
    input  logic [4:0]                uimm_i,
    input  logic                      rs1_zero_i,
    output logic                      done_o,
    output logic [CSR_DATA_WIDTH-1:0] rd_data_o,
    output logic                      illegal_o,
    output logic                      csr_en_o,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
    output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
    input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
    input  logic                      csr_busy_i,
    input  logic                      csr_exists_i,
    input  logic                      csr_ro_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [1:0]                r_kind;
    logic [CSR_ADDR_WIDTH-1:0] r_addr;
    logic [CSR_DATA_WIDTH-1:0] r_op;
    logic [CSR_DATA_WIDTH-1:0] r_old;
    logic                      r_rs1_zero;
    logic                      r_illegal;
    logic                      r_seen_busy;
    logic [CW-1:0]             r_cnt;

    logic                      w_accept;
    logic                      w_complete;
    logic                      w_timeout;
    logic                      w_need_write;
    logic [CSR_DATA_WIDTH-1:0] w_new;

    assign w_accept     = req_valid_i && (r_state == ST_IDLE);
    assign w_complete   = r_seen_busy && !csr_busy_i;
    assign w_timeout    = (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !w_complete;
    assign w_need_write = (r_kind == OP_RW) || !r_rs1_zero;

    csr_access_unit_alu #(.W(CSR_DATA_WIDTH)) u_alu (
        .i_kind (r_kind),
        .i_old  (r_old),
        .i_op   (r_op),
        .o_new  (w_new)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_next = f3_legal(funct3_i) ? ST_RD_REQ : ST_DONE;
            ST_RD_REQ:  w_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (w_complete)
                    w_next = (csr_exists_i && w_need_write && !csr_ro_i) ? ST_WR_REQ : ST_DONE;
                else if (w_timeout)
                    w_next = ST_DONE;
            end
            ST_WR_REQ:  w_next = ST_WR_WAIT;
            ST_WR_WAIT: if (w_complete || w_timeout) w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_kind      <= '0;
            r_addr      <= '0;
            r_op        <= '0;
            r_old       <= '0;
            r_rs1_zero  <= 1'b0;
            r_illegal   <= 1'b0;
            r_seen_busy <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_kind      <= funct3_i[1:0];
                    r_addr      <= addr_i;
                    r_op        <= funct3_i[2] ? {{(CSR_DATA_WIDTH-5){1'b0}}, uimm_i} : rs1_data_i;
                    r_rs1_zero  <= rs1_zero_i;
                    r_illegal   <= !f3_legal(funct3_i);
                    r_old       <= '0;
                end
                ST_RD_REQ, ST_WR_REQ: begin
                    r_seen_busy <= 1'b0;
                    r_cnt       <= '0;
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (csr_busy_i) r_seen_busy <= 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_state == ST_RD_WAIT && w_complete) begin
                        r_old <= csr_data_i;
                        if (!csr_exists_i || (w_need_write && csr_ro_i)) r_illegal <= 1'b1;
                    end
                    if (w_timeout) r_illegal <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Old value is suppressed on a trap so rd never sees a partial result
    assign req_ready_o = (r_state == ST_IDLE);
    assign csr_en_o    = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
    assign csr_we_o    = (r_state == ST_WR_REQ);
    assign csr_addr_o  = csr_en_o ? r_addr : '0;
    assign csr_data_o  = csr_we_o ? w_new : '0;
    assign done_o      = (r_state == ST_DONE);
    assign illegal_o   = done_o && r_illegal;
    assign rd_data_o   = (done_o && !r_illegal) ? r_old : '0;

endmodule
